// File: rtl/imem_boot_loader_pkg.sv
// Purpose : shared constants for the instruction-memory boot loader.
// Latency : n/a (package).
// Backpressure : n/a (package).
// Contents: FSM state encodings, stream framing constants.
package imem_boot_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);
  localparam int LEN_W          = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_LEN_HI = 3'd0;
  localparam state_t ST_LEN_LO = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_DONE   = 3'd3;
  localparam state_t ST_ERROR  = 3'd4;

endpackage : imem_boot_loader_pkg

// File: rtl/imem_word_assembler.sv
// Purpose : packs accepted bytes (MSB first) into 32-bit big-endian words.
// Latency : o_word_vld pulses the cycle after the edge accepting the 4th byte.
// Backpressure : none; the caller only strobes i_byte_vld on accepted transfers.
// Ports: clock/reset (async active-low), i_byte_vld/i_byte accepted byte,
//        o_byte_cnt position of the next byte within the word,
//        o_word_vld one-cycle word strobe, o_word assembled word.
module imem_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_byte_vld,
  input  logic [7:0]        i_byte,
  output logic [BCNT_W-1:0] o_byte_cnt,
  output logic              o_word_vld,
  output logic [WORD_W-1:0] o_word
);

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

  logic [BCNT_W-1:0]   r_cnt;
  logic [WORD_W-9:0]   r_shift;
  logic [WORD_W-1:0]   r_word;
  logic                r_word_vld;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_word     <= '0;
      r_word_vld <= 1'b0;
    end else begin
      r_word_vld <= 1'b0;
      if (i_byte_vld) begin
        if (r_cnt == LAST_BYTE) begin
          // Final byte completes the word; the shift register is refilled
          // completely by the next word's first three bytes, so no clear needed.
          r_word     <= {r_shift, i_byte};
          r_word_vld <= 1'b1;
          r_cnt      <= '0;
        end else begin
          r_shift <= {r_shift[WORD_W-17:0], i_byte};
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_byte_cnt = r_cnt;
  assign o_word_vld = r_word_vld;
  assign o_word     = r_word;

endmodule : imem_word_assembler

// File: rtl/imem_boot_loader.sv
// Purpose : loads a length-prefixed byte stream into instruction memory, then enables the PC.
// Latency : mem_we the cycle after a word's last byte; enablePC one cycle after the final write.
// Backpressure : in_ready high in LEN_HI/LEN_LO/DATA, low during reset, DONE and ERROR.
// Ports: clock/reset (async active-low), in_data/in_valid/in_ready byte stream,
//        mem_we/mem_addr/mem_wdata imem write port, enablePC, load_error, words_loaded.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              enablePC,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W:0]   r_words;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_enable_pc;

  logic              w_in_ready;
  logic              w_load_error;
  logic              w_xfer;
  logic              w_byte_acc;
  logic              w_word_done;
  logic              w_last_word;
  logic [LEN_W-1:0]  w_len_full;
  logic [BCNT_W-1:0] w_byte_cnt;
  logic              w_word_vld;
  logic [WORD_W-1:0] w_word;

  assign w_xfer      = in_valid && w_in_ready;
  assign w_byte_acc  = w_xfer && (r_state == ST_DATA);
  assign w_word_done = w_byte_acc && (w_byte_cnt == LAST_BYTE);
  // Full 16-bit header as seen on the edge accepting its low byte.
  assign w_len_full  = {r_len[LEN_W-1:8], in_data};
  assign w_last_word = (LEN_W'(r_words) + LEN_W'(1)) == r_len;

  imem_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .i_byte_vld (w_byte_acc),
    .i_byte     (in_data),
    .o_byte_cnt (w_byte_cnt),
    .o_word_vld (w_word_vld),
    .o_word     (w_word)
  );

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_LEN_HI;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LEN_HI: if (w_xfer) w_state_nxt = ST_LEN_LO;
      ST_LEN_LO: begin
        if (w_xfer) begin
          if (w_len_full == '0)                 w_state_nxt = ST_DONE;
          else if (w_len_full > LEN_W'(DEPTH))  w_state_nxt = ST_ERROR;
          else                                  w_state_nxt = ST_DATA;
        end
      end
      // DONE is entered on the same edge that raises the final mem_we.
      ST_DATA:   if (w_word_done && w_last_word) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_DONE;
      ST_ERROR:  w_state_nxt = ST_ERROR;
      default:   w_state_nxt = ST_ERROR;
    endcase
  end

  // FSM: outputs. in_ready is also gated by reset so every output reads 0 in reset.
  always_comb begin
    w_in_ready   = 1'b0;
    w_load_error = 1'b0;
    case (r_state)
      ST_LEN_HI, ST_LEN_LO, ST_DATA: w_in_ready   = reset;
      ST_ERROR:                      w_load_error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len       <= '0;
      r_words     <= '0;
      r_mem_addr  <= '0;
      r_enable_pc <= 1'b0;
    end else begin
      if (w_xfer && (r_state == ST_LEN_HI)) r_len[LEN_W-1:8] <= in_data;
      if (w_xfer && (r_state == ST_LEN_LO)) r_len[7:0]       <= in_data;
      if (w_word_done) begin
        r_mem_addr <= r_words[ADDR_W-1:0];
        r_words    <= r_words + 1'b1;
      end
      // One cycle behind DONE so the last write lands before the first fetch.
      r_enable_pc <= (r_state == ST_DONE);
    end
  end

  assign in_ready     = w_in_ready;
  assign load_error   = w_load_error;
  assign mem_we       = w_word_vld;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = w_word;
  assign enablePC     = r_enable_pc;
  assign words_loaded = r_words;

endmodule : imem_boot_loader

// File: tb/tb_imem_boot_loader.sv
// Purpose : directed self-checking bench for imem_boot_loader.
// Latency : n/a.
// Backpressure : drives in_valid gaps explicitly.
module tb_imem_boot_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        enablePC;
  logic        load_error;
  logic [8:0]  words_loaded;

  int n_assert = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int we_base;

  imem_boot_loader #(.ADDR_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .enablePC     (enablePC),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts write strobes seen between edges.
  always @(negedge clock) if (mem_we === 1'b1) we_cnt = we_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_enablePC", {31'd0, enablePC}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic chk_write(input string tag, input logic [7:0] addr,
                           input logic [31:0] data, input logic [8:0] cnt);
    chk({tag, "_we"},    {31'd0, mem_we}, 32'd1);
    chk({tag, "_addr"},  {24'd0, mem_addr}, {24'd0, addr});
    chk({tag, "_data"},  mem_wdata, data);
    chk({tag, "_words"}, {23'd0, words_loaded}, {23'd0, cnt});
  endtask

  initial begin
    logic [31:0] w;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    // Reset state
    chk("reset_in_ready",   {31'd0, in_ready}, 32'd0);
    chk("reset_mem_we",     {31'd0, mem_we}, 32'd0);
    chk("reset_mem_addr",   {24'd0, mem_addr}, 32'd0);
    chk("reset_mem_wdata",  mem_wdata, 32'd0);
    chk("reset_enablePC",   {31'd0, enablePC}, 32'd0);
    chk("reset_load_error", {31'd0, load_error}, 32'd0);
    chk("reset_words",      {23'd0, words_loaded}, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Normal load, full rate
    we_base = we_cnt;
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00);
    chk("n_no_early_we", {31'd0, mem_we}, 32'd0);
    send(8'h05);
    chk_write("n_w0", 8'h00, 32'h20080005, 9'd1);
    send(8'h01);
    chk("n_we_one_cycle", {31'd0, mem_we}, 32'd0);
    send(8'h09); send(8'h50); send(8'h20);
    chk_write("n_w1", 8'h01, 32'h01095020, 9'd2);
    chk("n_en_not_yet", {31'd0, enablePC}, 32'd0);
    chk("n_ready_done", {31'd0, in_ready}, 32'd0);
    idle(1);
    chk("n_enablePC", {31'd0, enablePC}, 32'd1);
    chk("n_we_after", {31'd0, mem_we}, 32'd0);
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    idle(1);
    chk("n_we_count", we_cnt - we_base, 32'd2);
    chk("n_words_hold", {23'd0, words_loaded}, 32'd2);

    // Gaps mid-word
    do_reset();
    we_base = we_cnt;
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08);
    idle(3);
    chk("g_no_we_gap", we_cnt - we_base, 32'd0);
    send(8'h00); send(8'h05);
    chk_write("g_w0", 8'h00, 32'h20080005, 9'd1);
    send(8'h01); send(8'h09); send(8'h50); send(8'h20);
    chk_write("g_w1", 8'h01, 32'h01095020, 9'd2);
    idle(1);
    chk("g_enablePC", {31'd0, enablePC}, 32'd1);
    chk("g_we_count", we_cnt - we_base, 32'd2);

    // Empty program
    do_reset();
    we_base = we_cnt;
    send(8'h00); send(8'h00);
    chk("e_ready_done", {31'd0, in_ready}, 32'd0);
    chk("e_en_not_yet", {31'd0, enablePC}, 32'd0);
    idle(1);
    chk("e_enablePC", {31'd0, enablePC}, 32'd1);
    chk("e_load_error", {31'd0, load_error}, 32'd0);
    chk("e_we_count", we_cnt - we_base, 32'd0);

    // Oversize header 257
    do_reset();
    we_base = we_cnt;
    send(8'h01); send(8'h01);
    chk("o_load_error", {31'd0, load_error}, 32'd1);
    chk("o_in_ready", {31'd0, in_ready}, 32'd0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    idle(2);
    chk("o_enablePC", {31'd0, enablePC}, 32'd0);
    chk("o_load_error_sticky", {31'd0, load_error}, 32'd1);
    chk("o_we_count", we_cnt - we_base, 32'd0);
    chk("o_words", {23'd0, words_loaded}, 32'd0);

    // Full capacity, 256 words
    do_reset();
    we_base = we_cnt;
    send(8'h01); send(8'h00);
    chk("f_ready_data", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      w = {i[7:0], 8'hC3, ~i[7:0], 8'h5A};
      send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
      chk_write("f_w", i[7:0], w, 9'(i + 1));
      if (i == 254) chk("f_en_mid", {31'd0, enablePC}, 32'd0);
    end
    chk("f_ready_done", {31'd0, in_ready}, 32'd0);
    idle(1);
    chk("f_enablePC", {31'd0, enablePC}, 32'd1);
    chk("f_we_count", we_cnt - we_base, 32'd256);
    chk("f_words_final", {23'd0, words_loaded}, 32'd256);

    // Reset while enabled drops enablePC asynchronously
    reset = 1'b0;
    #1;
    chk("r_en_drop", {31'd0, enablePC}, 32'd0);
    chk("r_words_clr", {23'd0, words_loaded}, 32'd0);
    tick();
    reset = 1'b1;
    #1;

    // Reset mid-load, then reload a single word
    we_base = we_cnt;
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    chk_write("m_w0", 8'h00, 32'h20080005, 9'd1);
    send(8'h01); send(8'h09);
    in_valid = 1'b0;
    chk("m_we_before_rst", we_cnt - we_base, 32'd1);
    do_reset();
    chk("m_words_after_rst", {23'd0, words_loaded}, 32'd0);
    chk("m_en_after_rst", {31'd0, enablePC}, 32'd0);
    we_base = we_cnt;
    send(8'h00); send(8'h01);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    chk_write("m_reload", 8'h00, 32'hDEADBEEF, 9'd1);
    chk("m_en_not_yet", {31'd0, enablePC}, 32'd0);
    idle(1);
    chk("m_enablePC", {31'd0, enablePC}, 32'd1);
    chk("m_we_count", we_cnt - we_base, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_imem_boot_loader
